// File: rtl/ulpi_hs_init_top.sv
// ulpi_hs_init_top
// ULPI link-side bring-up controller. All logic runs on the PHY's 60 MHz clock.
// Sequence after reset:
//   1. hold STP high for a power-up window;
//   2. write OTG Control (0x0A);
//   3. settle;
//   4. write Function Control (0x04) for full-speed with PHY reset;
//   5. wait for the PHY reset to finish;
//   6. qualify SE0 from RX CMD line state;
//   7. write Function Control for HS chirp;
//   8. send Chirp K;
//   9. idle with STP high.
//
// Ports:
//   USB_CLKIN   in     60 MHz ULPI clock, the only clock
//   RST         in     synchronous active-high reset
//   USB_DATA    inout  ULPI data; driven by the link only while USB_DIR=0
//   USB_DIR     in     PHY owns the bus when 1
//   USB_NXT     in     PHY throttle / accept
//   USB_STP     out    ULPI stop
//   USB_CS      out    PHY chip select, tied 1
//   USB_RESETN  out    PHY reset (active-low), tied 1
//   LED         out    status
//
// Optional feature, macro ULPI_LED_STATUS_EN:
//   defined   : LED = {2'b00, linestate, state index}
//   undefined : LED = 8'h00
module ulpi_hs_init_top #(
  parameter int unsigned PWRUP_CYCLES  = 7,
  parameter int unsigned SETTLE_CYCLES = 390000,
  parameter int unsigned SE0_CYCLES    = 150,
  parameter int unsigned CHIRP_CYCLES  = 120000
) (
  input  logic       USB_CLKIN,
  input  logic       RST,
  inout  logic [7:0] USB_DATA,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  output logic       USB_STP,
  output logic       USB_CS,
  output logic       USB_RESETN,
  output logic [7:0] LED
);

  // Encodings are fixed: they double as the LED state index.
  typedef enum logic [3:0] {
    PWRUP     = 4'd0,
    W_OTG     = 4'd1,
    SETTLE    = 4'd2,
    W_FCTL_FS = 4'd3,
    WAIT_RST  = 4'd4,
    DET_SE0   = 4'd5,
    W_FCTL_HS = 4'd6,
    CHIRP     = 4'd7,
    DONE      = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    RW_IDLE = 2'd0,
    RW_CMD  = 2'd1,
    RW_DATA = 2'd2,
    RW_STP  = 2'd3
  } rw_t;

  state_t      r_state;
  rw_t         r_rw;
  logic [31:0] r_cnt;
  logic        r_stp;
  logic [7:0]  r_dout;
  logic        r_dir_q;
  logic        r_seen_dir;
  logic [1:0]  r_ls;

  logic        w_rw_active;
  logic        w_rw_go;
  logic [5:0]  w_rw_addr;
  logic [7:0]  w_rw_data;
  state_t      w_rw_next;
  logic        w_rxcmd;

  assign USB_DATA   = USB_DIR ? 8'hzz : r_dout;
  assign USB_STP    = r_stp;
  assign USB_CS     = 1'b1;
  assign USB_RESETN = 1'b1;

  // RX CMD: PHY owns the bus, no NXT, and not the turnaround cycle.
  assign w_rxcmd = USB_DIR && !USB_NXT && r_dir_q;

`ifdef ULPI_LED_STATUS_EN
  assign LED = {2'b00, r_ls, r_state};
`else
  assign LED = '0;
`endif

  // Register-write parameters for the three states that use the REGW sequence.
  always_comb begin
    w_rw_active = 1'b0;
    w_rw_go     = !USB_DIR;
    w_rw_addr   = '0;
    w_rw_data   = '0;
    w_rw_next   = r_state;
    case (r_state)
      W_OTG: begin
        w_rw_active = 1'b1;
        w_rw_go     = !USB_DIR && !r_dir_q;  // two consecutive idle cycles
        w_rw_addr   = 6'h0A;
        w_rw_data   = 8'h00;
        w_rw_next   = SETTLE;
      end
      W_FCTL_FS: begin
        w_rw_active = 1'b1;
        w_rw_addr   = 6'h04;
        w_rw_data   = 8'h65;
        w_rw_next   = WAIT_RST;
      end
      W_FCTL_HS: begin
        w_rw_active = 1'b1;
        w_rw_addr   = 6'h04;
        w_rw_data   = 8'h54;
        w_rw_next   = CHIRP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge USB_CLKIN) begin
    if (RST) begin
      r_state    <= PWRUP;
      r_rw       <= RW_IDLE;
      r_cnt      <= '0;
      r_stp      <= 1'b1;
      r_dout     <= '0;
      r_dir_q    <= 1'b1;
      r_seen_dir <= 1'b0;
      r_ls       <= '0;
    end else begin
      r_dir_q <= USB_DIR;
      if (w_rxcmd)
        r_ls <= USB_DATA[1:0];

      if (w_rw_active) begin
        case (r_rw)
          RW_IDLE: begin
            if (w_rw_go) begin
              r_dout <= {2'b10, w_rw_addr};
              r_rw   <= RW_CMD;
            end
          end
          RW_CMD: begin
            if (USB_DIR) begin
              r_dout <= '0;
              r_rw   <= RW_IDLE;
            end else if (USB_NXT) begin
              r_dout <= w_rw_data;
              r_rw   <= RW_DATA;
            end
          end
          RW_DATA: begin
            if (USB_DIR) begin
              r_dout <= '0;
              r_rw   <= RW_IDLE;
            end else if (USB_NXT) begin
              r_stp  <= 1'b1;
              r_dout <= '0;
              r_rw   <= RW_STP;
            end
          end
          // Data byte already accepted; the STP cycle always completes.
          RW_STP: begin
            r_stp   <= 1'b0;
            r_rw    <= RW_IDLE;
            r_cnt   <= '0;
            r_state <= w_rw_next;
          end
          default: r_rw <= RW_IDLE;
        endcase
      end else begin
        case (r_state)
          PWRUP: begin
            if (r_cnt == PWRUP_CYCLES - 1) begin
              r_stp   <= 1'b0;
              r_cnt   <= '0;
              r_state <= W_OTG;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          SETTLE: begin
            if (r_cnt == SETTLE_CYCLES - 1) begin
              r_cnt   <= '0;
              r_state <= W_FCTL_FS;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          WAIT_RST: begin
            if (USB_DIR) begin
              r_seen_dir <= 1'b1;
            end else if (r_seen_dir) begin
              r_seen_dir <= 1'b0;
              r_cnt      <= '0;
              r_state    <= DET_SE0;
            end
          end
          // Non-SE0 line state clears the run; PHY-owned cycles neither
          // count nor clear unless they deliver a new line state.
          DET_SE0: begin
            if (r_ls != 2'b00) begin
              r_cnt <= '0;
            end else if (!USB_DIR) begin
              if (r_cnt == SE0_CYCLES - 1) begin
                r_cnt   <= '0;
                r_state <= W_FCTL_HS;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          CHIRP: begin
            if (!USB_DIR) begin
              if (r_cnt == CHIRP_CYCLES - 1) begin
                r_stp   <= 1'b1;
                r_cnt   <= '0;
                r_state <= DONE;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          DONE: begin
            r_stp  <= 1'b1;
            r_dout <= '0;
          end
          W_OTG, W_FCTL_FS, W_FCTL_HS: ;
          default: r_state <= PWRUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulpi_hs_init_top.sv
// Directed bench for ulpi_hs_init_top with short settle/chirp windows.
// The PHY side is modelled by driving USB_DATA only while dir=1.
module tb_ulpi_hs_init_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       dir;
  logic       nxt;
  logic [7:0] phy;
  wire  [7:0] usb_data;
  logic       stp;
  logic       cs;
  logic       resetn;
  logic [7:0] led;

  int n_chk = 0;
  int n_bad = 0;

  assign usb_data = dir ? phy : 8'hzz;

  always #8 clk = ~clk;

`ifdef ULPI_LED_STATUS_EN
  localparam logic [7:0] LED_LS01 = 8'h15;
  localparam logic [7:0] LED_DONE = 8'h08;
`else
  localparam logic [7:0] LED_LS01 = 8'h00;
  localparam logic [7:0] LED_DONE = 8'h00;
`endif

  ulpi_hs_init_top #(
    .PWRUP_CYCLES (7),
    .SETTLE_CYCLES(100),
    .SE0_CYCLES   (150),
    .CHIRP_CYCLES (300)
  ) dut (
    .USB_CLKIN (clk),
    .RST       (rst),
    .USB_DATA  (usb_data),
    .USB_DIR   (dir),
    .USB_NXT   (nxt),
    .USB_STP   (stp),
    .USB_CS    (cs),
    .USB_RESETN(resetn),
    .LED       (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input logic [7:0] v, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (usb_data !== v && n < lim);
  endtask

  task automatic wait_stp(input logic v, input int lim, output int n, output int nz);
    n  = 0;
    nz = 0;
    do begin
      step();
      n++;
      if (!dir && stp !== v && usb_data !== 8'h00) nz++;
    end while (stp !== v && n < lim);
  endtask

  task automatic rx_cmd(input logic [7:0] d, input int cycles);
    dir = 1'b1;
    phy = d;
    repeat (cycles) step();
    dir = 1'b0;
    phy = 8'h00;
  endtask

  task automatic low_run(input int cycles, output int nz);
    nz  = 0;
    dir = 1'b0;
    repeat (cycles) begin
      step();
      if (usb_data !== 8'h00) nz++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nz;

    rst = 1'b1;
    dir = 1'b1;
    nxt = 1'b0;
    phy = 8'h00;
    repeat (3) step();
    check("rst_stp", 32'(stp), 32'd1);
    check("rst_bus", 32'(usb_data), 32'h00);
    check("rst_led", 32'(led), 32'h00);
    check("cs_resetn", 32'({cs, resetn}), 32'h3);

    rst = 1'b0;
    wait_stp(1'b0, 50, n, nz);
    check("pwrup_len", n, 7);

    // OTG Control write
    dir = 1'b0;
    step();
    check("otg_idle", 32'(usb_data), 32'h00);
    step();
    check("otg_txcmd", 32'(usb_data), 32'h8A);
    step();
    check("otg_hold", 32'(usb_data), 32'h8A);
    nxt = 1'b1;
    step();
    check("otg_data", 32'({stp, usb_data}), 32'h000);
    step();
    check("otg_stp", 32'({stp, usb_data}), 32'h100);
    nxt = 1'b0;
    step();
    check("otg_stp_end", 32'(stp), 32'd0);

    // Settle then Function Control (FS + reset), aborted once by DIR
    wait_bus(8'h84, 500, n);
    check("settle_len", n, 101);
    step();
    check("fs_hold", 32'(usb_data), 32'h84);
    dir = 1'b1;
    phy = 8'h00;
    #1;
    check("abort_z", 32'(usb_data), 32'h00);
    step();
    step();
    dir = 1'b0;
    #1;
    check("abort_clr", 32'(usb_data), 32'h00);
    step();
    check("abort_restart", 32'(usb_data), 32'h84);
    nxt = 1'b1;
    step();
    check("fs_data", 32'(usb_data), 32'h65);
    step();
    check("fs_stp", 32'({stp, usb_data}), 32'h100);
    nxt = 1'b0;
    step();
    check("fs_stp_end", 32'(stp), 32'd0);

    // PHY reset pulse, then SE0 qualification
    rx_cmd(8'h00, 16);
    step();
    rx_cmd(8'h54, 2);
    low_run(100, nz);
    check("se0_run1_quiet", nz, 0);
    rx_cmd(8'h01, 2);
    #1;
    check("led_ls01", 32'(led), 32'(LED_LS01));
    low_run(200, nz);
    check("ls01_no_write", nz, 0);
    rx_cmd(8'h54, 2);
    low_run(100, nz);
    check("se0_run2_quiet", nz, 0);
    rx_cmd(8'h00, 3);
    wait_bus(8'h84, 400, n);
    check("se0_freeze_len", n, 51);

    // Function Control (HS chirp) then Chirp K with NXT held high
    nxt = 1'b1;
    step();
    check("hs_data", 32'(usb_data), 32'h54);
    step();
    check("hs_stp", 32'({stp, usb_data}), 32'h100);
    step();
    check("hs_stp_end", 32'(stp), 32'd0);
    wait_stp(1'b1, 1000, n, nz);
    check("chirp_len", n, 300);
    check("chirp_data", nz, 0);
    check("done_led", 32'(led), 32'(LED_DONE));
    repeat (3) step();
    check("done_stp", 32'({stp, usb_data}), 32'h100);
    nxt = 1'b0;

    // Reset from DONE
    rst = 1'b1;
    step();
    check("rerst_stp_led", 32'({stp, led}), 32'h100);
    rst = 1'b0;
    wait_stp(1'b0, 50, n, nz);
    check("rerst_pwrup", n, 7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
